// File: rtl/bpu.sv
// Branch prediction unit: direct-mapped BTB with a 2-bit saturating
// direction counter per entry, plus branch/mispredict counters.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   f_pc               fetch PC being looked up (combinational lookup)
//   pred_hit           f_pc matches a valid entry
//   pred_taken         hit and counter MSB set
//   pred_target        taken ? stored target : f_pc + 4
//   u_valid/u_pc/u_taken/u_target/u_mispredict
//                      resolved conditional branch report, trains the table
//   stat_branches      number of u_valid cycles
//   stat_mispredicts   number of u_valid && u_mispredict cycles
module bpu #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] f_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  input  logic        u_valid,
  input  logic [63:0] u_pc,
  input  logic        u_taken,
  input  logic [63:0] u_target,
  input  logic        u_mispredict,
  output logic [63:0] stat_branches,
  output logic [63:0] stat_mispredicts
);
  localparam int N   = 1 << IDX_BITS;
  localparam int TLO = IDX_BITS + 2;
  localparam int THI = IDX_BITS + TAG_BITS + 1;

  logic [N-1:0]        valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [N];
  logic [TAG_BITS-1:0] tag_d [N];
  logic [63:0]         tgt_q [N];
  logic [63:0]         tgt_d [N];
  logic [1:0]          ctr_q [N];
  logic [1:0]          ctr_d [N];
  logic [63:0]         br_q, br_d, mp_q, mp_d;

  logic [IDX_BITS-1:0] fidx, uidx;
  logic [TAG_BITS-1:0] ftag, utag;
  logic                u_hit, u_we;

  assign fidx = f_pc[IDX_BITS+1:2];
  assign ftag = f_pc[THI:TLO];
  assign uidx = u_pc[IDX_BITS+1:2];
  assign utag = u_pc[THI:TLO];

  // PC bits outside index/tag never participate in lookup or training.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[63:THI+1], f_pc[1:0], u_pc[63:THI+1], u_pc[1:0]};

  // Lookup reads the registered table only, so an update in the same cycle
  // becomes visible one cycle later.
  always_comb begin
    pred_hit    = valid_q[fidx] && (tag_q[fidx] == ftag);
    pred_taken  = pred_hit && ctr_q[fidx][1];
    pred_target = pred_taken ? tgt_q[fidx] : f_pc + 64'd4;
  end

  assign u_hit = valid_q[uidx] && (tag_q[uidx] == utag);
  // Reset suppresses training so a reset+update cycle leaves nothing behind.
  assign u_we  = u_valid && !reset;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    br_d    = br_q;
    mp_d    = mp_q;
    if (u_we) begin
      br_d = br_q + 64'd1;
      if (u_mispredict) mp_d = mp_q + 64'd1;
      if (u_hit) begin
        if (u_taken) begin
          ctr_d[uidx] = (ctr_q[uidx] == 2'd3) ? 2'd3 : ctr_q[uidx] + 2'd1;
          tgt_d[uidx] = u_target;
        end else begin
          ctr_d[uidx] = (ctr_q[uidx] == 2'd0) ? 2'd0 : ctr_q[uidx] - 2'd1;
        end
      end else if (u_taken) begin
        // Allocate or replace on a taken miss; not-taken misses never evict.
        valid_d[uidx] = 1'b1;
        tag_d[uidx]   = utag;
        tgt_d[uidx]   = u_target;
        ctr_d[uidx]   = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      br_q    <= '0;
      mp_q    <= '0;
    end else begin
      valid_q <= valid_d;
      br_q    <= br_d;
      mp_q    <= mp_d;
    end
  end

  // Payload storage is not reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    ctr_q <= ctr_d;
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;
endmodule

// File: tb/tb_bpu.sv
// Scoreboard bench for bpu: expected values are queued as stimulus is
// driven and compared when the DUT outputs are sampled.
module tb_bpu;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] f_pc;
  logic        pred_hit, pred_taken;
  logic [63:0] pred_target;
  logic        u_valid, u_taken, u_mispredict;
  logic [63:0] u_pc, u_target;
  logic [63:0] stat_branches, stat_mispredicts;

  bpu #(.IDX_BITS(6), .TAG_BITS(10)) dut (
    .clk(clk), .reset(reset), .f_pc(f_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_target(u_target),
    .u_mispredict(u_mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;   // 0 hit, 1 taken, 2 target, 3 branches, 4 mispredicts
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    q.push_back(e);
  endtask

  // Compare every queued expectation against current DUT outputs.
  task automatic drain();
    exp_t e;
    logic [63:0] got;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0:       got = {63'd0, pred_hit};
        1:       got = {63'd0, pred_taken};
        2:       got = pred_target;
        3:       got = stat_branches;
        default: got = stat_mispredicts;
      endcase
      chk(e.tag, got, e.exp);
    end
  endtask

  // Drive a fetch PC away from the clock edge and check the lookup.
  task automatic look(input string tag, input logic [63:0] pc, input logic h,
                      input logic t, input logic [63:0] tgt);
    @(negedge clk);
    f_pc = pc;
    push({tag, ".hit"}, 0, {63'd0, h});
    push({tag, ".taken"}, 1, {63'd0, t});
    push({tag, ".target"}, 2, tgt);
    #1 drain();
  endtask

  task automatic stats(input string tag, input logic [63:0] b, input logic [63:0] m);
    @(negedge clk);
    push({tag, ".branches"}, 3, b);
    push({tag, ".mispredicts"}, 4, m);
    #1 drain();
  endtask

  task automatic upd(input logic [63:0] pc, input logic t, input logic [63:0] tgt,
                     input logic mp);
    @(negedge clk);
    u_valid = 1'b1; u_pc = pc; u_taken = t; u_target = tgt; u_mispredict = mp;
    @(negedge clk);
    u_valid = 1'b0; u_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  localparam logic [63:0] PA = 64'h8000_0010;
  localparam logic [63:0] PB = 64'h8000_0110;  // aliases PA (same index)
  localparam logic [63:0] PC = 64'h8000_0210;  // aliases PA too

  initial begin
    reset = 1'b1; f_pc = 64'h8000_0000;
    u_valid = 1'b0; u_pc = '0; u_taken = 1'b0; u_target = '0; u_mispredict = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    look("rst", 64'h8000_0000, 0, 0, 64'h8000_0004);
    stats("rst", 0, 0);
    look("wrap4", 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0);

    // Allocation and counter training on one PC.
    upd(PA, 1, 64'h8000_0100, 0);
    look("alloc", PA, 1, 1, 64'h8000_0100);
    upd(PA, 0, 64'h0, 1);
    look("ctr1", PA, 1, 0, 64'h8000_0014);
    upd(PA, 0, 64'h0, 0);
    look("ctr0", PA, 1, 0, 64'h8000_0014);
    upd(PA, 0, 64'h0, 0);                 // stays at 0
    upd(PA, 1, 64'h8000_0100, 0);         // -> 1
    look("sat0", PA, 1, 0, 64'h8000_0014);
    upd(PA, 1, 64'h8000_0100, 0);         // -> 2
    upd(PA, 1, 64'h8000_0100, 0);         // -> 3
    upd(PA, 1, 64'h8000_0200, 1);         // stays 3, new target
    upd(PA, 0, 64'h0, 0);                 // -> 2, target kept
    look("sat3", PA, 1, 1, 64'h8000_0200);
    stats("train", 9, 2);

    // Aliasing: taken replaces, not-taken never evicts.
    upd(PB, 1, 64'h8000_0300, 0);
    look("alias.old", PA, 0, 0, 64'h8000_0014);
    look("alias.new", PB, 1, 1, 64'h8000_0300);
    upd(PC, 0, 64'h0, 0);
    look("alias.keep", PB, 1, 1, 64'h8000_0300);
    look("alias.third", PC, 0, 0, 64'h8000_0214);
    look("lowbits", PB | 64'h3, 1, 1, 64'h8000_0300);

    // Mid-operation reset clears the table.
    do_reset();
    look("rst2", PB, 0, 0, 64'h8000_0114);

    // Same-cycle lookup and update: no bypass.
    @(negedge clk);
    f_pc = 64'h8000_0040;
    u_valid = 1'b1; u_pc = 64'h8000_0040; u_taken = 1'b1; u_target = 64'h8000_0400;
    push("same.now", 0, 64'd0);
    #1 drain();
    @(negedge clk);
    u_valid = 1'b0;
    push("same.next", 0, 64'd1);
    push("same.tgt", 2, 64'h8000_0400);
    #1 drain();

    // Counters: 5 branches, 2 mispredicts, and a stray mispredict/taken
    // while u_valid is low that must be ignored.
    do_reset();
    upd(64'h8000_1000, 0, 64'h0, 1);
    upd(64'h8000_1004, 0, 64'h0, 0);
    @(negedge clk);
    u_valid = 1'b0; u_mispredict = 1'b1; u_pc = 64'h8000_0500; u_taken = 1'b1;
    u_target = 64'h8000_0900;
    @(negedge clk);
    u_mispredict = 1'b0; u_taken = 1'b0;
    upd(64'h8000_1008, 0, 64'h0, 0);
    upd(64'h8000_100C, 0, 64'h0, 1);
    upd(64'h8000_1010, 0, 64'h0, 0);
    stats("cnt", 5, 2);
    look("ghost", 64'h8000_0500, 0, 0, 64'h8000_0504);

    // Reset together with a valid update: reset wins.
    @(negedge clk);
    reset = 1'b1;
    u_valid = 1'b1; u_pc = 64'h8000_0600; u_taken = 1'b1; u_target = 64'h8000_0a00;
    u_mispredict = 1'b1;
    @(negedge clk);
    reset = 1'b0; u_valid = 1'b0; u_mispredict = 1'b0;
    stats("rstupd", 0, 0);
    look("rstupd.tbl", 64'h8000_0600, 0, 0, 64'h8000_0604);
    look("rstupd.old", 64'h8000_0040, 0, 0, 64'h8000_0044);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bpu.md
Name: bpu

Overview:
- Fetch-side branch prediction unit: a direct-mapped BTB with one 2-bit saturating direction counter per entry.
- Fetch queries it with the current PC and gets a predicted next PC in the same cycle.
- Execute reports each resolved conditional branch (taken/not-taken from the branch-resolution unit, plus target), and the table trains on those reports.
- Also keeps branch and mispredict performance counters.

Parameters:
- IDX_BITS, 6: log2 of entry count (64 entries); index = pc[IDX_BITS+1:2].
- TAG_BITS, 10: tag width; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- f_pc  in  64  fetch PC being looked up.
- pred_hit  out  1  f_pc matches a valid entry (index + tag).
- pred_taken  out  1  predicted taken.
- pred_target  out  64  predicted next PC.
- u_valid  in  1  resolved conditional branch present this cycle.
- u_pc  in  64  PC of resolved branch.
- u_taken  in  1  actual direction from branch resolution.
- u_target  in  64  actual taken target, pc + B-immediate.
- u_mispredict  in  1  fetch's earlier prediction for this branch was wrong (direction or target).
- stat_branches  out  64  count of u_valid cycles.
- stat_mispredicts  out  64  count of u_valid && u_mispredict cycles.

Behaviour:
- Storage per entry: valid (1), tag (TAG_BITS), target (64), ctr (2).
  - Valid bits are a flop vector cleared in one cycle by reset.
  - tag/target/ctr are not reset.
- Reset: all valid=0; stat_branches=0; stat_mispredicts=0.
  - With all entries invalid, outputs reduce to pred_hit=0, pred_taken=0, pred_target=f_pc+4.
- Lookup is purely combinational from f_pc and current table state (0-cycle latency):
  - pred_hit = valid[idx] && tag[idx]==ftag.
  - pred_taken = pred_hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : f_pc+4; the add is 64-bit, wrapping.
- Update (u_valid=1), applied at the next rising edge, using entry uidx/utag from u_pc:
  - Hit, taken: ctr = min(ctr+1, 3); target = u_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss (invalid or tag mismatch), taken: allocate/replace the entry with valid=1, tag=utag, target=u_target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no table change; never evict on not-taken.
- Counters: stat_branches += 1 per u_valid cycle; stat_mispredicts += 1 when u_valid && u_mispredict. Both wrap modulo 2^64. u_mispredict is ignored when u_valid=0.
- Simultaneous lookup and update to the same index in one cycle: lookup sees the pre-update state (no bypass). The update is visible from the next cycle.
- Only one update per cycle. u_* fields are don't-care when u_valid=0 and must not affect state.
- Reset asserted together with u_valid: reset wins; no update, counters stay 0.
- Reset mid-operation: all predictions revert to not-hit the cycle after reset samples high.
- No handshake or back-pressure: update is fire-and-forget, accepted every cycle.
- Low pc bits [1:0] are ignored for index and tag.

Test Plan:
- After reset, f_pc=0x8000_0000 -> pred_hit=0, pred_taken=0, pred_target=0x8000_0004; both stat counters are 0.
- Update u_pc=0x8000_0010, u_taken=1, u_target=0x8000_0100 -> next cycle, f_pc=0x8000_0010 gives pred_hit=1, pred_taken=1, pred_target=0x8000_0100 (ctr=2).
- Same PC, two not-taken updates -> after the first, ctr=1, pred_taken=0, pred_target=0x8000_0014. After the second, ctr=0. Three taken updates then saturate at ctr=3, and one not-taken update leaves pred_taken=1.
- Aliasing: u_pc=0x8000_0010 allocated, then taken update at u_pc=0x8000_0010 + (1<<(IDX_BITS+2)) -> the entry is replaced; lookup of the original PC gives pred_hit=0. A not-taken update for a third aliasing PC does not evict.
- Same-cycle lookup/update of the same PC from an empty table -> pred_hit=0 that cycle, 1 the next.
- 5 u_valid pulses with u_mispredict on 2 of them, plus u_mispredict=1 with u_valid=0 -> stat_branches=5, stat_mispredicts=2. Reset asserted together with u_valid -> both stat counters read 0 afterwards and the table is empty.
